// File: rtl/mmio_fifo_pkg.sv
// Shared register map, status/control bit positions and the packed STATUS
// word layout for the MMIO FIFO register block.
package mmio_fifo_pkg;

   localparam logic [15:0] OFF_DATA   = 16'd0;
   localparam logic [15:0] OFF_STATUS = 16'd2;
   localparam logic [15:0] OFF_CTRL   = 16'd4;
   localparam logic [15:0] OFF_PEEK   = 16'd6;
   localparam logic [15:0] OFF_LAST   = 16'd6;

   localparam int ST_EMPTY_BIT = 32;
   localparam int ST_FULL_BIT  = 33;
   localparam int ST_OVF_BIT   = 34;
   localparam int ST_UNF_BIT   = 35;
   localparam int ST_DEPTH_LSB = 48;

   localparam int CTRL_FLUSH_BIT = 0;
   localparam int CTRL_CLR_BIT   = 1;

   typedef struct packed {
      logic [15:0] depth;
      logic [11:0] rsvd;
      logic        underflow;
      logic        overflow;
      logic        full;
      logic        empty;
      logic [31:0] count;
   } status_t;

endpackage

// File: rtl/fifo_core.sv
// Circular-buffer storage with push/pop/flush; full and empty come from the
// occupancy count so pointers can wrap freely.
module fifo_core #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [DATA_W-1:0]       wdata,
   output logic [DATA_W-1:0]       head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [AW:0]       count_q, count_d;
   logic              do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (do_push && !do_pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   // NOTE: storage has no reset; its contents are unobservable until written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         end
      end
   end

endmodule

// File: rtl/mmio_fifo_csr.sv
// MMIO-mapped FIFO register block: address decode, sticky error flags and a
// one-cycle registered read response for the Tx c2 path.
module mmio_fifo_csr
   import mmio_fifo_pkg::*;
#(
   parameter int          DATA_W    = 64,
   parameter int          DEPTH     = 8,
   parameter logic [15:0] BASE_ADDR = 16'h0020
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mmio_wr_valid,
   input  logic                   mmio_rd_valid,
   input  logic [15:0]            mmio_addr,
   input  logic [8:0]             mmio_tid,
   input  logic [63:0]            mmio_wr_data,
   output logic                   rd_hit,
   output logic                   rd_resp_valid,
   output logic [8:0]             rd_resp_tid,
   output logic [63:0]            rd_resp_data,
   output logic [$clog2(DEPTH):0] fifo_count
);

   logic [15:0]       offset;
   logic              in_block, rd_req, push_req, pop_req, ctrl_wr, flush, clr_sticky;
   logic              ovf_set, unf_set;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              full, empty;
   logic [DATA_W-1:0] head;
   logic [63:0]       rd_mux, head_ext;
   status_t           status;
   logic              rd_resp_valid_q, rd_hit_q;
   logic [8:0]        rd_resp_tid_q;
   logic [63:0]       rd_resp_data_q;
   logic              unused_wr_data;

   assign offset   = mmio_addr - BASE_ADDR;
   assign in_block = (mmio_addr >= BASE_ADDR) && (offset <= OFF_LAST);
   assign rd_req   = mmio_rd_valid && in_block;
   assign push_req = mmio_wr_valid && in_block && (offset == OFF_DATA);
   assign pop_req  = rd_req && (offset == OFF_DATA);
   assign ctrl_wr  = mmio_wr_valid && in_block && (offset == OFF_CTRL);
   assign flush      = ctrl_wr && mmio_wr_data[CTRL_FLUSH_BIT];
   assign clr_sticky = ctrl_wr && mmio_wr_data[CTRL_CLR_BIT];
   assign unused_wr_data = ^mmio_wr_data;

   // Full implies non-empty, so a same-cycle pop always frees the slot.
   assign ovf_set = push_req && full && !pop_req;
   assign unf_set = pop_req && empty;
   assign ovf_d   = (ovf_q && !clr_sticky) || ovf_set;
   assign unf_d   = (unf_q && !clr_sticky) || unf_set;

   fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_core (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop_req),
      .flush (flush),
      .wdata (mmio_wr_data[DATA_W-1:0]),
      .head  (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign head_ext = empty ? 64'h0 : 64'(head);

   always_comb begin
      status           = '0;
      status.depth     = 16'(DEPTH);
      status.underflow = unf_q;
      status.overflow  = ovf_q;
      status.full      = full;
      status.empty     = empty;
      status.count     = 32'(fifo_count);
      case (offset)
         OFF_DATA, OFF_PEEK: rd_mux = head_ext;
         OFF_STATUS:         rd_mux = status;
         default:            rd_mux = 64'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q           <= 1'b0;
         unf_q           <= 1'b0;
         rd_resp_valid_q <= 1'b0;
         rd_hit_q        <= 1'b0;
         rd_resp_tid_q   <= '0;
         rd_resp_data_q  <= '0;
      end else begin
         ovf_q           <= ovf_d;
         unf_q           <= unf_d;
         rd_resp_valid_q <= rd_req;
         rd_hit_q        <= rd_req;
         if (rd_req) begin
            rd_resp_tid_q  <= mmio_tid;
            rd_resp_data_q <= rd_mux;
         end
      end
   end

   assign rd_resp_valid = rd_resp_valid_q;
   assign rd_hit        = rd_hit_q;
   assign rd_resp_tid   = rd_resp_tid_q;
   assign rd_resp_data  = rd_resp_data_q;

endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Scoreboard bench for mmio_fifo_csr: a behavioural FIFO model predicts each
// read response, which is queued at issue and compared when the DUT answers.
module tb_mmio_fifo_csr;
   import mmio_fifo_pkg::*;

   localparam int          DEPTH = 8;
   localparam logic [15:0] BASE  = 16'h0020;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0, rd_valid = 1'b0;
   logic [15:0] addr = '0;
   logic [8:0]  tid = '0;
   logic [63:0] wr_data = '0;
   logic        rd_hit, rd_resp_valid;
   logic [8:0]  rd_resp_tid;
   logic [63:0] rd_resp_data;
   logic [3:0]  fifo_count;

   logic        w16_wr = 1'b0, w16_rd = 1'b0;
   logic [15:0] w16_addr = '0;
   logic [8:0]  w16_tid = '0;
   logic [63:0] w16_wdata = '0;
   logic        w16_hit, w16_valid;
   logic [8:0]  w16_rtid;
   logic [63:0] w16_rdata;
   logic [3:0]  w16_count;

   always #5 clk = ~clk;

   mmio_fifo_csr #(.DATA_W(64), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .mmio_wr_valid(wr_valid), .mmio_rd_valid(rd_valid),
      .mmio_addr(addr), .mmio_tid(tid), .mmio_wr_data(wr_data),
      .rd_hit(rd_hit), .rd_resp_valid(rd_resp_valid), .rd_resp_tid(rd_resp_tid),
      .rd_resp_data(rd_resp_data), .fifo_count(fifo_count)
   );

   mmio_fifo_csr #(.DATA_W(16), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut16 (
      .clk(clk), .rst(rst), .mmio_wr_valid(w16_wr), .mmio_rd_valid(w16_rd),
      .mmio_addr(w16_addr), .mmio_tid(w16_tid), .mmio_wr_data(w16_wdata),
      .rd_hit(w16_hit), .rd_resp_valid(w16_valid), .rd_resp_tid(w16_rtid),
      .rd_resp_data(w16_rdata), .fifo_count(w16_count)
   );

   typedef struct {
      logic [8:0]  tid;
      logic [63:0] data;
   } rsp_t;

   rsp_t        sb[$];
   logic [63:0] mq[$];
   logic        m_ovf = 1'b0, m_unf = 1'b0;
   logic [63:0] last_data = '0;
   int          n_cmp = 0, n_err = 0;

   function automatic logic [63:0] model_status();
      logic [63:0] s;
      s = '0;
      s[31:0]                        = 32'(mq.size());
      s[ST_EMPTY_BIT]                = (mq.size() == 0);
      s[ST_FULL_BIT]                 = (mq.size() == DEPTH);
      s[ST_OVF_BIT]                  = m_ovf;
      s[ST_UNF_BIT]                  = m_unf;
      s[ST_DEPTH_LSB +: 16]          = 16'(DEPTH);
      return s;
   endfunction

   // One bus cycle on the 64-bit instance: predict, drive, then compare.
   task automatic cycle(input string name, input logic wr, input logic rd,
                        input logic [15:0] a, input logic [63:0] wd, input logic [8:0] t);
      logic [15:0] off;
      logic        inblk, do_pop, new_ovf, new_unf;
      logic [63:0] exp;
      rsp_t        r;
      off   = a - BASE;
      inblk = (a >= BASE) && (off <= 16'd6);
      case (off)
         16'd0, 16'd6: exp = (mq.size() == 0) ? 64'h0 : mq[0];
         16'd2:        exp = model_status();
         default:      exp = 64'h0;
      endcase
      if (rd && inblk) sb.push_back('{tid: t, data: exp});
      do_pop  = rd && inblk && off == 16'd0 && mq.size() != 0;
      new_unf = rd && inblk && off == 16'd0 && mq.size() == 0;
      new_ovf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (wr && inblk && off == 16'd0) begin
         if (mq.size() < DEPTH) mq.push_back(wd);
         else new_ovf = 1'b1;
      end
      if (wr && inblk && off == 16'd4) begin
         if (wd[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
         if (wd[0]) mq.delete();
      end
      m_ovf = m_ovf | new_ovf;
      m_unf = m_unf | new_unf;

      wr_valid = wr; rd_valid = rd; addr = a; wr_data = wd; tid = t;
      @(negedge clk);
      wr_valid = 1'b0; rd_valid = 1'b0;

      n_cmp++;
      if (rd_resp_valid !== (rd && inblk) || rd_hit !== (rd && inblk)) begin
         n_err++;
         $display("FAIL %s valid/hit got %b/%b want %b", name, rd_resp_valid, rd_hit, rd && inblk);
      end
      if (rd_resp_valid === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s unexpected response data %h", name, rd_resp_data);
         end else begin
            r = sb.pop_front();
            last_data = r.data;
            if (rd_resp_tid !== r.tid || rd_resp_data !== r.data) begin
               n_err++;
               $display("FAIL %s tid/data got %0d/%h want %0d/%h", name, rd_resp_tid,
                        rd_resp_data, r.tid, r.data);
            end
         end
      end
      n_cmp++;
      if (fifo_count !== 4'(mq.size())) begin
         n_err++;
         $display("FAIL %s fifo_count got %0d want %0d", name, fifo_count, mq.size());
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({rd_hit, rd_resp_valid, rd_resp_tid, rd_resp_data, fifo_count} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got %b/%b/%h/%h/%0d want all 0", rd_hit, rd_resp_valid,
                  rd_resp_tid, rd_resp_data, fifo_count);
      end
      rst = 1'b0;
      @(negedge clk);
      cycle("reset_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd5);
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 8; i++) cycle("fill_push", 1'b1, 1'b0, BASE, 64'(i * 'h11), 9'd0);
      cycle("overflow_push", 1'b1, 1'b0, BASE, 64'h99, 9'd0);
      cycle("overflow_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd1);
      for (int i = 0; i < 8; i++) cycle("drain_pop", 1'b0, 1'b1, BASE, 64'h0, 9'(16 + i));
      cycle("underflow_pop", 1'b0, 1'b1, BASE, 64'h0, 9'd30);
      cycle("underflow_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd31);
      cycle("clear_sticky", 1'b1, 1'b0, BASE + 16'd4, 64'h2, 9'd0);
      cycle("cleared_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd32);
   endtask

   task automatic test_push_pop_full();
      for (int i = 1; i <= 8; i++) cycle("full_fill", 1'b1, 1'b0, BASE, 64'(i * 'h11), 9'd0);
      cycle("full_push_pop", 1'b1, 1'b1, BASE, 64'hAA, 9'd40);
      cycle("full_pp_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd41);
      for (int i = 0; i < 8; i++) cycle("full_drain", 1'b0, 1'b1, BASE, 64'h0, 9'(50 + i));
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         cycle("wrap_push", 1'b1, 1'b0, BASE, 64'h1000 + 64'(2 * i), 9'd0);
         cycle("wrap_push", 1'b1, 1'b0, BASE, 64'h1001 + 64'(2 * i), 9'd0);
         cycle("wrap_pop", 1'b0, 1'b1, BASE, 64'h0, 9'(100 + 2 * i));
         cycle("wrap_pop", 1'b0, 1'b1, BASE, 64'h0, 9'(101 + 2 * i));
      end
   endtask

   task automatic test_push_pop_empty();
      cycle("empty_push_pop", 1'b1, 1'b1, BASE, 64'h5A5A, 9'd60);
      cycle("empty_pp_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd61);
      cycle("peek", 1'b0, 1'b1, BASE + 16'd6, 64'h0, 9'd62);
      cycle("status_rd_wr", 1'b1, 1'b1, BASE + 16'd2, 64'hFFFF, 9'd63);
      cycle("ctrl_read_zero", 1'b0, 1'b1, BASE + 16'd4, 64'h0, 9'd64);
   endtask

   task automatic test_flush_clear();
      for (int i = 0; i < 3; i++) cycle("flush_push", 1'b1, 1'b0, BASE, 64'h300 + 64'(i), 9'd0);
      cycle("flush_ctrl", 1'b1, 1'b0, BASE + 16'd4, 64'h3, 9'd0);
      cycle("flush_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd70);
      cycle("flush_peek_empty", 1'b0, 1'b1, BASE + 16'd6, 64'h0, 9'd71);
   endtask

   task automatic test_map_edges();
      logic [63:0] held;
      cycle("odd_offset", 1'b0, 1'b1, BASE + 16'd1, 64'h0, 9'd80);
      cycle("status_hold_src", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd81);
      held = last_data;
      cycle("above_block", 1'b0, 1'b1, BASE + 16'd7, 64'h0, 9'd82);
      cycle("below_block", 1'b0, 1'b1, BASE - 16'd1, 64'h0, 9'd83);
      cycle("oob_write", 1'b1, 1'b0, BASE + 16'd8, 64'h77, 9'd0);
      n_cmp++;
      if (rd_resp_data !== held) begin
         n_err++;
         $display("FAIL data_hold got %h want %h", rd_resp_data, held);
      end
   endtask

   task automatic test_width16();
      @(negedge clk);
      w16_wr = 1'b1; w16_addr = BASE; w16_wdata = 64'hDEAD_BEEF_1234_5678;
      @(negedge clk);
      w16_wr = 1'b0; w16_rd = 1'b1; w16_addr = BASE + 16'd6; w16_tid = 9'd3;
      @(negedge clk);
      w16_rd = 1'b0;
      n_cmp++;
      if (w16_valid !== 1'b1 || w16_rtid !== 9'd3 || w16_rdata !== 64'h5678 || w16_count !== 4'd1) begin
         n_err++;
         $display("FAIL w16_peek valid/tid/data/count got %b/%0d/%h/%0d want 1/3/5678/1",
                  w16_valid, w16_rtid, w16_rdata, w16_count);
      end
      w16_rd = 1'b1; w16_addr = BASE; w16_tid = 9'd4;
      @(negedge clk);
      w16_rd = 1'b0;
      n_cmp++;
      if (w16_valid !== 1'b1 || w16_rtid !== 9'd4 || w16_rdata !== 64'h5678 || w16_count !== 4'd0) begin
         n_err++;
         $display("FAIL w16_pop valid/tid/data/count got %b/%0d/%h/%0d want 1/4/5678/0",
                  w16_valid, w16_rtid, w16_rdata, w16_count);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) cycle("rst_push", 1'b1, 1'b0, BASE, 64'h400 + 64'(i), 9'd0);
      cycle("rst_pre_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd90);
      rd_valid = 1'b1; addr = BASE; tid = 9'd91;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({rd_hit, rd_resp_valid, rd_resp_tid, rd_resp_data, fifo_count} !== '0) begin
         n_err++;
         $display("FAIL async_reset got %b/%b/%h/%h/%0d want all 0", rd_hit, rd_resp_valid,
                  rd_resp_tid, rd_resp_data, fifo_count);
      end
      @(negedge clk);
      rd_valid = 1'b0;
      rst = 1'b0;
      mq.delete(); sb.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rd_resp_valid !== 1'b0 || rd_hit !== 1'b0 || fifo_count !== 4'd0) begin
         n_err++;
         $display("FAIL reset_drop got %b/%b/%0d want 0/0/0", rd_resp_valid, rd_hit, fifo_count);
      end
      cycle("post_reset_status", 1'b0, 1'b1, BASE + 16'd2, 64'h0, 9'd92);
   endtask

   initial begin
      test_reset();
      test_fill_overflow();
      test_push_pop_full();
      test_wrap();
      test_push_pop_empty();
      test_flush_clear();
      test_map_edges();
      test_width16();
      test_async_reset();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
